pingpong_ring: RTL and testbench
================================

PINGPONG_RING -- requirements
Module: pingpong_ring

Interface
REQ-001 Parameter NUM_CH, default 2, number of ring participants (legal 2..16).
REQ-002 Parameter HOP_DELAY, default 1, clock cycles between consecutive hits (legal 1..255).
REQ-003 Parameter START_DELAY, default 100, lead-in cycles before the first hop (legal 0..65535).
REQ-004 Parameter ROUNDS, default 10, full ring traversals before completion (legal 1..65535).
REQ-005 clk  input  1  single clock; all state is on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  level-sampled launch request; acted on only in IDLE or DONE.
REQ-008 hold  input  1  freezes all counters and state while high.
REQ-009 hit  output  NUM_CH  one-hot, one-cycle pulse marking the participant receiving the token.
REQ-010 owner  output  CH_W  index of the current token holder.
REQ-011 round_cnt  output  16  completed rounds.
REQ-012 busy  output  1  high in LEAD or WAIT.
REQ-013 done  output  1  high in DONE.

Function
REQ-014 The FSM SHALL have the states IDLE, LEAD, WAIT and DONE.
REQ-015 IDLE/DONE with start=1: clear round_cnt, set owner=0, load lead counter; go to LEAD, or directly to WAIT if START_DELAY=0.
REQ-016 LEAD SHALL last exactly START_DELAY non-held cycles, then enter WAIT with the hop counter loaded.
REQ-017 WAIT SHALL assert hit[owner] on its HOP_DELAY-th non-held cycle, then advance owner modulo NUM_CH and reload the hop counter.
REQ-018 The first hit SHALL occur START_DELAY+HOP_DELAY cycles after the cycle in which start is sampled; later hits SHALL follow every HOP_DELAY cycles.
REQ-019 A hit on owner=NUM_CH-1 SHALL increment round_cnt in the same edge; owner wraps to 0.
REQ-020 When that increment makes round_cnt equal ROUNDS, the FSM SHALL enter DONE on the same edge and issue no further hits.
REQ-021 Exactly NUM_CH*ROUNDS hits SHALL be emitted per run.
REQ-022 start while busy SHALL be ignored.
REQ-023 start in DONE SHALL relaunch per REQ-015; done drops on the same edge.
REQ-024 hold=1 SHALL suppress hit and freeze counters, owner and state; timing resumes exactly where it stopped.
REQ-025 hold takes priority over start in IDLE/DONE.
REQ-026 The hop and lead counters SHALL be sized from HOP_DELAY and START_DELAY, with no overflow at the legal maxima.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE, hit=0, owner=0, round_cnt=0, busy=0, done=0, all counters 0.
REQ-028 Reset mid-run SHALL abort the run with no residual hit; the first post-reset hit requires a new start.
REQ-029 Deassertion timing is the integrator's responsibility; no internal synchroniser.

Structure
REQ-030 Package pingpong_ring_pkg SHALL hold the state enum, CH_W=$clog2(NUM_CH) helper function, and the 16-bit round width constant.
REQ-031 One sub-module, pingpong_ring_timer (loadable down-counter with enable and zero flag), SHALL be instantiated twice (lead, hop).
REQ-032 The design SHALL be fully synthesisable: no delays, events or initial blocks.

Verification
REQ-033 Defaults, start pulse at cycle 0 -> hit[0] at cycle 101, hit[1] at 102, alternating, 20 hits, round_cnt=10, done at cycle 121.
REQ-034 NUM_CH=4, HOP_DELAY=3, START_DELAY=0, ROUNDS=2, start at 0 -> hits at cycles 3,6,...,24 in order 0,1,2,3,0,1,2,3; done at 25.
REQ-035 Defaults, hold high for cycles 105..109 -> every later hit shifted by 5 cycles, done at 126, hit count still 20.
REQ-036 Defaults, rst_n low at cycle 110 -> all outputs 0 asynchronously; no hits until a new start, after which REQ-033 timing is repeated relative to that start.
REQ-037 Start re-pulsed at cycle 50 (busy) -> ignored; start at cycle 130 in DONE -> done drops, first hit at cycle 231.

Source files
------------

// File: rtl/pingpong_ring_pkg.sv
// Shared types and width helpers for the ping-pong token ring.
package pingpong_ring_pkg;

   localparam int ROUND_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bits needed to hold max_val itself, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/pingpong_ring_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
module pingpong_ring_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !zero) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pingpong_ring.sv
// Token ring sequencer: after a lead-in, passes a one-hot hit around NUM_CH
// participants every HOP_DELAY cycles for ROUNDS full traversals.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LEAD  | counting START_DELAY lead-in cycles
//   WAIT  | counting down to the next hop; hit fires on terminal count
//   DONE  | all rounds completed, waiting for a relaunch
module pingpong_ring
   import pingpong_ring_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int HOP_DELAY   = 1,
   parameter int START_DELAY = 100,
   parameter int ROUNDS      = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        hold,
   output logic [NUM_CH-1:0]           hit,
   output logic [ch_w(NUM_CH)-1:0]     owner,
   output logic [ROUND_W-1:0]          round_cnt,
   output logic                        busy,
   output logic                        done
);

   localparam int CH_W      = ch_w(NUM_CH);
   localparam int LEAD_W    = cnt_w(START_DELAY);
   localparam int HOP_W     = cnt_w(HOP_DELAY);
   // Timers load N-1 so the terminal-count cycle is the Nth one.
   localparam int LEAD_LOAD = (START_DELAY > 0) ? START_DELAY - 1 : 0;
   localparam int HOP_LOAD  = HOP_DELAY - 1;
   localparam logic [CH_W-1:0]    LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(ROUNDS);

   state_t               state, state_nxt;
   logic [CH_W-1:0]      owner_nxt;
   logic [ROUND_W-1:0]   round_nxt, round_inc;
   logic                 lead_load, lead_en, lead_zero;
   logic                 hop_load, hop_en, hop_zero;
   logic                 fire;

   pingpong_ring_timer #(.W(LEAD_W)) u_lead (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lead_load),
      .load_val (LEAD_W'(LEAD_LOAD)),
      .en       (lead_en),
      .zero     (lead_zero)
   );

   pingpong_ring_timer #(.W(HOP_W)) u_hop (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (hop_load),
      .load_val (HOP_W'(HOP_LOAD)),
      .en       (hop_en),
      .zero     (hop_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         round_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         round_cnt <= round_nxt;
      end
   end

   assign round_inc = round_cnt + ROUND_W'(1);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      round_nxt = round_cnt;
      lead_load = 1'b0;
      lead_en   = 1'b0;
      hop_load  = 1'b0;
      hop_en    = 1'b0;
      fire      = 1'b0;
      // hold freezes everything, including a pending launch.
      if (!hold) begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  round_nxt = '0;
                  owner_nxt = '0;
                  if (START_DELAY == 0) begin
                     state_nxt = WAIT;
                     hop_load  = 1'b1;
                  end else begin
                     state_nxt = LEAD;
                     lead_load = 1'b1;
                  end
               end
            end
            LEAD: begin
               if (lead_zero) begin
                  state_nxt = WAIT;
                  hop_load  = 1'b1;
               end else begin
                  lead_en = 1'b1;
               end
            end
            WAIT: begin
               if (hop_zero) begin
                  fire     = 1'b1;
                  hop_load = 1'b1;
                  if (owner == LAST_CH) begin
                     owner_nxt = '0;
                     round_nxt = round_inc;
                     if (round_inc == LAST_RND) state_nxt = DONE;
                  end else begin
                     owner_nxt = owner + CH_W'(1);
                  end
               end else begin
                  hop_en = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign hit  = fire ? (NUM_CH'(1) << owner) : '0;
   assign busy = (state == LEAD) || (state == WAIT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_pingpong_ring.sv
// Scoreboard bench for pingpong_ring: a default instance and a 4-participant,
// zero-lead instance share the same start/hold/reset stimulus.
module tb_pingpong_ring;

   typedef struct {
      int          cyc;
      logic [15:0] vec;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n, start, hold;
   logic [1:0]  hit0;
   logic [0:0]  owner0;
   logic [15:0] round0;
   logic        busy0, done0;
   logic [3:0]  hit1;
   logic [1:0]  owner1;
   logic [15:0] round1;
   logic        busy1, done1;

   pingpong_ring dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .hit(hit0), .owner(owner0), .round_cnt(round0), .busy(busy0), .done(done0)
   );

   pingpong_ring #(.NUM_CH(4), .HOP_DELAY(3), .START_DELAY(0), .ROUNDS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .hit(hit1), .owner(owner1), .round_cnt(round1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   int nch[2] = '{2, 4};
   int hdl[2] = '{1, 3};
   int sdl[2] = '{100, 0};
   int rnd[2] = '{10, 2};

   // Reference model: mode 0 idle, 1 running, 2 done; ee = non-held cycles since launch.
   int md[2], ee[2], nh[2];
   int exp_busy[2], exp_done[2], exp_owner[2], exp_round[2];
   ev_t q0[$], q1[$];

   int first_hit[2], hits_run[2], done_rise[2], prev_done[2];

   task automatic chk(input string nm, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic model(input int id);
      int   n, sd, hd, r, e1;
      logic fire;
      ev_t  ev;
      n = nch[id]; sd = sdl[id]; hd = hdl[id]; r = rnd[id];
      if (!rst_n) begin
         md[id] = 0; ee[id] = 0; nh[id] = 0;
         exp_busy[id] = 0; exp_done[id] = 0; exp_owner[id] = 0; exp_round[id] = 0;
         if (id == 0) q0.delete(); else q1.delete();
         return;
      end
      exp_busy[id]  = (md[id] == 1) ? 1 : 0;
      exp_done[id]  = (md[id] == 2) ? 1 : 0;
      exp_owner[id] = nh[id] % n;
      exp_round[id] = nh[id] / n;
      e1   = ee[id] + 1;
      fire = (md[id] == 1) && !hold && (e1 >= sd + hd) && ((e1 - sd) % hd == 0);
      if (fire) begin
         ev.cyc = cyc;
         ev.vec = 16'(1) << (nh[id] % n);
         if (id == 0) q0.push_back(ev); else q1.push_back(ev);
      end
      if (!hold) begin
         if (md[id] == 1) begin
            ee[id] = e1;
            if (fire) begin
               nh[id]++;
               if (nh[id] == n * r) md[id] = 2;
            end
         end else if (start) begin
            md[id] = 1; ee[id] = 0; nh[id] = 0;
         end
      end
   endtask

   task automatic step(input logic st, input logic hd, input logic rs);
      @(posedge clk);
      #1;
      start = st; hold = hd; rst_n = rs;
      model(0);
      model(1);
   endtask

   task automatic arm();
      for (int i = 0; i < 2; i++) begin
         first_hit[i] = -1; hits_run[i] = 0; done_rise[i] = -1;
      end
   endtask

   task automatic mon(input int id, input logic [15:0] hv, input logic b, input logic d,
                      input int own, input int rc);
      ev_t  ev;
      logic have;
      have = 1'b0;
      if (id == 0) begin
         if (q0.size() > 0) begin have = 1'b1; ev = q0[0]; end
      end else begin
         if (q1.size() > 0) begin have = 1'b1; ev = q1[0]; end
      end
      chk($sformatf("busy%0d", id),  int'(b), exp_busy[id]);
      chk($sformatf("done%0d", id),  int'(d), exp_done[id]);
      chk($sformatf("owner%0d", id), own,     exp_owner[id]);
      chk($sformatf("round%0d", id), rc,      exp_round[id]);
      if (hv != 16'd0) begin
         hits_run[id]++;
         if (first_hit[id] < 0) first_hit[id] = cyc;
         if (!have) begin
            tests++; fails++;
            $display("FAIL unexpected_hit%0d: got hit=%0h, expected none (cycle %0d)", id, hv, cyc);
         end else begin
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("hit_cycle%0d", id), cyc, ev.cyc);
            chk($sformatf("hit_vec%0d", id), int'(hv), int'(ev.vec));
         end
      end else if (have && ev.cyc <= cyc) begin
         tests++; fails++;
         $display("FAIL missed_hit%0d: got none, expected hit=%0h at cycle %0d", id, ev.vec, ev.cyc);
         if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (d && prev_done[id] == 0 && done_rise[id] < 0) done_rise[id] = cyc;
      prev_done[id] = int'(d);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, 16'(hit0), busy0, done0, int'(owner0), int'(round0));
         mon(1, 16'(hit1), busy1, done1, int'(owner1), int'(round1));
      end
   end

   initial begin
      int s;
      for (int i = 0; i < 2; i++) begin
         md[i] = 0; ee[i] = 0; nh[i] = 0; prev_done[i] = 0;
         exp_busy[i] = 0; exp_done[i] = 0; exp_owner[i] = 0; exp_round[i] = 0;
      end
      arm();
      rst_n = 1'b0; start = 1'b0; hold = 1'b0;
      #3;
      chk("reset_hit0",   int'(hit0),   0);
      chk("reset_owner0", int'(owner0), 0);
      chk("reset_round0", int'(round0), 0);
      chk("reset_busy0",  int'(busy0),  0);
      chk("reset_done0",  int'(done0),  0);
      chk("reset_hit1",   int'(hit1),   0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 1);

      // Launch, ignored re-pulse while busy, relaunch from DONE.
      s = 0;
      for (int i = 0; i <= 260; i++) begin
         step((i == 0) || (i == 50) || (i == 130), 0, 1);
         if (i == 0) begin s = cyc; arm(); end
         if (i == 49) begin
            chk("b_first1", first_hit[1], s + 3);
            chk("b_done1",  done_rise[1], s + 25);
            chk("b_hits1",  hits_run[1],  8);
         end
         if (i == 129) begin
            chk("a_first0", first_hit[0], s + 101);
            chk("a_done0",  done_rise[0], s + 121);
            chk("a_hits0",  hits_run[0],  20);
            chk("a_round0", int'(round0), 10);
         end
         if (i == 130) arm();
         if (i == 131) begin
            chk("relaunch_done0", int'(done0), 0);
            chk("relaunch_busy0", int'(busy0), 1);
         end
      end
      chk("relaunch_first0", first_hit[0], s + 231);
      chk("relaunch_done0r", done_rise[0], s + 251);
      chk("relaunch_hits0",  hits_run[0],  20);

      // Hold for five cycles mid-run.
      for (int i = 0; i <= 150; i++) begin
         step(i == 0, (i >= 105) && (i <= 109), 1);
         if (i == 0) begin s = cyc; arm(); end
      end
      chk("hold_first0", first_hit[0], s + 101);
      chk("hold_done0",  done_rise[0], s + 126);
      chk("hold_hits0",  hits_run[0],  20);

      // Asynchronous reset mid-run, then a fresh launch.
      for (int i = 0; i <= 260; i++) begin
         step((i == 0) || (i == 120), 0, !((i >= 110) && (i <= 112)));
         if (i == 110) begin
            #1;
            chk("midrst_hit0",   int'(hit0),   0);
            chk("midrst_owner0", int'(owner0), 0);
            chk("midrst_round0", int'(round0), 0);
            chk("midrst_busy0",  int'(busy0),  0);
            chk("midrst_done0",  int'(done0),  0);
            chk("midrst_done1",  int'(done1),  0);
            arm();
         end
         if (i == 119) begin
            chk("postrst_nohit0", hits_run[0], 0);
            chk("postrst_nohit1", hits_run[1], 0);
         end
         if (i == 120) begin s = cyc; arm(); end
      end
      chk("postrst_first0", first_hit[0], s + 101);
      chk("postrst_done0",  done_rise[0], s + 121);
      chk("postrst_hits0",  hits_run[0],  20);

      // Randomised start/hold traffic, then drain.
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, 1);
      end
      for (int i = 0; i < 300; i++) step(0, 0, 1);
      @(negedge clk);
      #1;
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
